// File: rtl/instr_fetch.sv
// Instruction fetch: PC, in-order imem request/grant/rvalid, response FIFO to decode.
// Optional `INSTR_FETCH_BYPASS_EN: a kept response reaches decode combinationally when the FIFO is empty.
//
// state | meaning
// IDLE  | out of reset, no requests issued
// RUN   | fetching
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]   outst_q, outst_d;
  logic [CNT_W-1:0]   discard_q, discard_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]        fifo_instr_q [BUF_DEPTH];
  logic [31:0]        fifo_instr_d [BUF_DEPTH];
  logic [31:0]        fifo_pc_q    [BUF_DEPTH];
  logic [31:0]        fifo_pc_d    [BUF_DEPTH];

  logic [31:0]  redirect_pc_al;
  logic [CNT_W:0] level;
  logic         req;
  logic         grant;
  logic         keep;
  logic         push;
  logic         pop;

  always_comb begin
    state_d        = RUN;
    pc_d           = pc_q;
    resp_pc_d      = resp_pc_q;
    outst_d        = outst_q;
    discard_d      = discard_q;
    count_d        = count_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    fifo_instr_d   = fifo_instr_q;
    fifo_pc_d      = fifo_pc_q;
    redirect_pc_al = {redirect_pc_i[31:2], 2'b00};

    level = {1'b0, outst_q} + {1'b0, count_q};
    req   = (state_q == RUN) && !redirect_i && (level < DEPTH_C);
    grant = req && imem_gnt_i;
    keep  = imem_rvalid_i && (discard_q == '0) && !redirect_i;
    pop   = (count_q != '0) && instr_ready_i && !redirect_i;

`ifdef INSTR_FETCH_BYPASS_EN
    instr_valid_o = (count_q != '0) || (keep && (count_q == '0));
    instr_o       = (count_q != '0) ? fifo_instr_q[rd_ptr_q] : imem_rdata_i;
    instr_pc_o    = (count_q != '0) ? fifo_pc_q[rd_ptr_q]    : resp_pc_q;
    // a bypassed instruction taken by decode never enters the FIFO
    push          = keep && !((count_q == '0) && instr_ready_i);
`else
    instr_valid_o = (count_q != '0);
    instr_o       = fifo_instr_q[rd_ptr_q];
    instr_pc_o    = fifo_pc_q[rd_ptr_q];
    push          = keep;
`endif

    outst_d = outst_q + CNT_W'(grant) - CNT_W'(imem_rvalid_i);

    if (redirect_i) begin
      // outst_q already counts pending discards, so every remaining in-flight response is dropped
      discard_d = outst_q - CNT_W'(imem_rvalid_i);
      pc_d      = redirect_pc_al;
      resp_pc_d = redirect_pc_al;
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
    end else begin
      if (imem_rvalid_i && (discard_q != '0)) discard_d = discard_q - 1'b1;
      if (grant) pc_d = pc_q + 32'd4;
      if (keep) resp_pc_d = resp_pc_q + 32'd4;
      if (push) begin
        fifo_instr_d[wr_ptr_q] = imem_rdata_i;
        fifo_pc_d[wr_ptr_q]    = resp_pc_q;
        wr_ptr_d               = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    imem_req_o  = req;
    imem_addr_o = pc_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      resp_pc_q    <= RESET_PC;
      outst_q      <= '0;
      discard_q    <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      resp_pc_q    <= resp_pc_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: in-order memory model with stale
// tagging on redirect; a monitor pops expected {instr, pc} on every decode transfer.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  instr_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {logic [31:0] addr; int due; bit stale;} mreq_t;
  typedef struct {logic [31:0] instr; logic [31:0] pc;} exp_t;

  mreq_t       memq[$];
  exp_t        expq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          run_m = 0;
  bit          active = 0;
  bit          prev_redirect = 0;
  logic [31:0] model_pc = RST_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus plus the reference model's view of what happens at the next edge.
  task automatic cycle(input int p_gnt, input int p_ready, input int p_redir,
                       input int lat_max, input logic [31:0] force_pc);
    bit    exp_req;
    mreq_t m;
    int    sel;
    @(negedge clk_i);
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(memq[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    imem_gnt_i    = ($urandom_range(99) < p_gnt);
    instr_ready_i = ($urandom_range(99) < p_ready);
    redirect_i    = run_m && ($urandom_range(99) < p_redir);
    if (p_redir >= 100) redirect_pc_i = force_pc;
    else begin
      sel = $urandom_range(3);
      redirect_pc_i = (sel == 0) ? 32'h0000_0203 :
                      (sel == 1) ? 32'hFFFF_FFF9 : $urandom;
    end
    #1;
    exp_req = run_m && !redirect_i && (memq.size() + expq.size() < DEPTH);
    chk("req", imem_req_o, exp_req);
    if (exp_req) chk("addr", imem_addr_o, model_pc);
    if (prev_redirect) chk("valid_after_redirect", instr_valid_o, 0);

    if (imem_rvalid_i) begin
      m = memq.pop_front();
      if (!m.stale && !redirect_i) expq.push_back('{mem_word(m.addr), m.addr});
    end
    if (exp_req && imem_gnt_i) begin
      memq.push_back('{model_pc, cyc + $urandom_range(lat_max, 1), 1'b0});
      model_pc = model_pc + 32'd4;
    end
    if (redirect_i) begin
      foreach (memq[i]) memq[i].stale = 1'b1;
      expq.delete();
      model_pc = {redirect_pc_i[31:2], 2'b00};
    end
    prev_redirect = redirect_i;
    cyc++;
  endtask

  task automatic quiet_inputs();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    instr_ready_i = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("req_at_release", imem_req_o, 0);
    memq.delete();
    expq.delete();
    model_pc      = RST_PC;
    prev_redirect = 0;
    run_m         = 1;
    active        = 1;
  endtask

  // Monitor: compares each decode transfer against the scoreboard queue.
  logic [31:0] hold_instr, hold_pc;
  bit          hold_p = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (active) begin
        if (hold_p) begin
          chk("hold_valid", instr_valid_o, 1);
          chk("hold_instr", instr_o, hold_instr);
          chk("hold_pc", instr_pc_o, hold_pc);
        end
        if (expq.size() == 0 && !redirect_i) chk("valid_when_empty", instr_valid_o, 0);
        if (instr_valid_o && instr_ready_i && !redirect_i) begin
          if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_instr actual=%h required=none", instr_o);
          end else begin
            e = expq.pop_front();
            chk("instr", instr_o, e.instr);
            chk("instr_pc", instr_pc_o, e.pc);
          end
        end
        hold_p     = instr_valid_o && !instr_ready_i && !redirect_i;
        hold_instr = instr_o;
        hold_pc    = instr_pc_o;
      end else begin
        hold_p = 0;
      end
    end
  end

  initial begin
    int guard;
    rst_i = 1'b0;
    quiet_inputs();
    #12;
    chk("rst_req", imem_req_o, 0);
    chk("rst_addr", imem_addr_o, RST_PC);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", instr_pc_o, 32'h0);
    release_reset();

    // streaming from 0x100 with a 1-cycle memory
    repeat (12) cycle(100, 100, 0, 1, 32'h0);
    // decode stalled: requests must stop at the buffer cap, head held
    repeat (10) cycle(100, 0, 0, 1, 32'h0);
    repeat (10) cycle(100, 100, 0, 1, 32'h0);
    // redirect with requests in flight, then wrap-around redirect
    repeat (2) cycle(100, 100, 0, 3, 32'h0);
    cycle(100, 100, 100, 3, 32'h0000_0203);
    repeat (8) cycle(100, 100, 0, 1, 32'h0);
    cycle(100, 100, 100, 1, 32'hFFFF_FFF9);
    repeat (8) cycle(100, 100, 0, 1, 32'h0);
    // redirect in the same cycle as a response and a pop
    repeat (3) cycle(100, 100, 0, 1, 32'h0);
    cycle(100, 100, 100, 1, 32'h0000_0040);
    repeat (4) cycle(100, 100, 0, 2, 32'h0);

    repeat (600) cycle(70, 70, 4, 3, 32'h0);

    // asynchronous reset mid-stream
    @(negedge clk_i);
    quiet_inputs();
    #3;
    active = 0;
    run_m  = 0;
    rst_i  = 1'b0;
    #1;
    chk("midrst_req", imem_req_o, 0);
    chk("midrst_valid", instr_valid_o, 0);
    chk("midrst_addr", imem_addr_o, RST_PC);
    repeat (2) @(negedge clk_i);
    release_reset();
    repeat (4) cycle(100, 100, 0, 1, 32'h0);
    repeat (300) cycle(60, 80, 3, 3, 32'h0);

    guard = 0;
    while ((expq.size() != 0 || memq.size() != 0) && guard < 50) begin
      cycle(0, 100, 0, 3, 32'h0);
      guard++;
    end
    chk("drained", expq.size(), 0);
    repeat (2) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
